// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - FP32 constants, complex field positions and rounding arithmetic helpers.
// Build option MAC_RNE_EN selects round-to-nearest-even instead of truncation.
package mac_pkg;

  localparam int FP32_W = 32;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  localparam logic [FP32_W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [FP32_W-1:0] PINF = 32'h7F80_0000;

  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

`ifdef MAC_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  // m carries the hidden bit; g is the first dropped bit, st the OR of the rest.
  function automatic logic [FP32_W-1:0] fp32_pack(input logic s, input logic signed [11:0] e,
                                                  input logic [MANT_W:0] m, input logic g,
                                                  input logic st);
    logic [MANT_W+1:0] mr;
    logic signed [11:0] er;
    mr = {1'b0, m};
    if (RNE_EN && g && (st || m[0])) mr = mr + 1'b1;
    er = e;
    if (mr[MANT_W+1]) begin
      mr = mr >> 1;
      er = er + 12'sd1;
    end
    if (er >= 12'sd255) return {s, PINF[FP32_W-2:0]};
    if (er <= 12'sd0) return {s, 31'd0};
    return {s, er[EXP_W-1:0], mr[MANT_W-1:0]};
  endfunction

  function automatic logic [FP32_W-1:0] fp32_mul(input logic [FP32_W-1:0] a,
                                                 input logic [FP32_W-1:0] b);
    logic s;
    logic [47:0] p;
    logic signed [11:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'd0};
    p = {1'b1, a[MANT_W-1:0]} * {1'b1, b[MANT_W-1:0]};
    e = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'(BIAS);
    if (p[47]) return fp32_pack(s, e + 12'sd1, p[47:24], p[23], |p[22:0]);
    return fp32_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [FP32_W-1:0] fp32_add(input logic [FP32_W-1:0] a,
                                                 input logic [FP32_W-1:0] b);
    logic [FP32_W-1:0] x, y, t;
    logic [50:0] mx, my, sm, lost, sum;
    logic [7:0] d;
    logic [5:0] p;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    x = (a[30:23] == 8'h00) ? {a[31], 31'd0} : a;
    y = (b[30:23] == 8'h00) ? {b[31], 31'd0} : b;
    if (x[30:0] < y[30:0]) begin
      t = x;
      x = y;
      y = t;
    end
    if (y[30:0] == 31'd0) begin
      if (x[30:0] == 31'd0) return {x[31] & y[31], 31'd0};
      return x;
    end
    mx = {1'b0, 1'b1, x[MANT_W-1:0], 26'd0};
    my = {1'b0, 1'b1, y[MANT_W-1:0], 26'd0};
    d  = x[30:23] - y[30:23];
    // Bits shifted out of the smaller operand are jammed into the LSB as sticky.
    if (d > 8'd50) begin
      sm = 51'd1;
    end else begin
      lost = my & ((51'd1 << d) - 51'd1);
      sm   = (my >> d) | {50'd0, |lost};
    end
    sum = (x[31] == y[31]) ? mx + sm : mx - sm;
    if (sum == 51'd0) return 32'd0;
    p = 6'd0;
    for (int i = 0; i < 51; i++) if (sum[i]) p = 6'(i);
    sum = sum << (6'd50 - p);
    return fp32_pack(x[31], $signed({4'd0, x[30:23]}) + $signed({6'd0, p}) - 12'sd49,
                     sum[50:27], sum[26], |sum[25:0]);
  endfunction

endpackage

// File: rtl/mac_cmul.sv
// rtl/mac_cmul.sv - combinational complex product W*B with separately rounded steps.
// Rounding mode follows MAC_RNE_EN through mac_pkg.
module mac_cmul
  import mac_pkg::*;
(
  input  logic [63:0] i_w,
  input  logic [63:0] i_b,
  output logic [63:0] o_p
);

  logic [31:0] w_rr, w_ii, w_ri, w_ir;

  assign w_rr = fp32_mul(i_w[RE_MSB:RE_LSB], i_b[RE_MSB:RE_LSB]);
  assign w_ii = fp32_mul(i_w[IM_MSB:IM_LSB], i_b[IM_MSB:IM_LSB]);
  assign w_ri = fp32_mul(i_w[RE_MSB:RE_LSB], i_b[IM_MSB:IM_LSB]);
  assign w_ir = fp32_mul(i_w[IM_MSB:IM_LSB], i_b[RE_MSB:RE_LSB]);

  // Subtraction is an add with the subtrahend's sign flipped; NaN stays NaN.
  assign o_p[RE_MSB:RE_LSB] = fp32_add(w_rr, {~w_ii[31], w_ii[30:0]});
  assign o_p[IM_MSB:IM_LSB] = fp32_add(w_ri, w_ir);

endmodule

// File: rtl/mac.sv
// rtl/mac.sv - complex butterfly Y1 = A + W1*B, Y2 = A + W2*B, one-cycle registered.
// Define MAC_RNE_EN for round-to-nearest-even; default build truncates.
module mac
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic [63:0] w1,
  input  logic [63:0] w2,
  output logic [63:0] out1,
  output logic [63:0] out2
);

  logic [63:0] w_p1, w_p2, w_y1, w_y2;
  logic [63:0] r_out1, r_out2;

  mac_cmul u_cmul1 (.i_w(w1), .i_b(in2), .o_p(w_p1));
  mac_cmul u_cmul2 (.i_w(w2), .i_b(in2), .o_p(w_p2));

  assign w_y1[RE_MSB:RE_LSB] = fp32_add(in1[RE_MSB:RE_LSB], w_p1[RE_MSB:RE_LSB]);
  assign w_y1[IM_MSB:IM_LSB] = fp32_add(in1[IM_MSB:IM_LSB], w_p1[IM_MSB:IM_LSB]);
  assign w_y2[RE_MSB:RE_LSB] = fp32_add(in1[RE_MSB:RE_LSB], w_p2[RE_MSB:RE_LSB]);
  assign w_y2[IM_MSB:IM_LSB] = fp32_add(in1[IM_MSB:IM_LSB], w_p2[IM_MSB:IM_LSB]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out1 <= 64'h0;
      r_out2 <= 64'h0;
    end else begin
      r_out1 <= w_y1;
      r_out2 <= w_y2;
    end
  end

  assign out1 = r_out1;
  assign out2 = r_out2;

endmodule

// File: tb/tb_mac.sv
// tb/tb_mac.sv - directed self-checking bench for mac; rounding expectations follow MAC_RNE_EN.
module tb_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in1, in2, w1, w2;
  logic [63:0] out1, out2;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac dut (
    .clk(clk), .reset(reset),
    .in1(in1), .in2(in2), .w1(w1), .w2(w2),
    .out1(out1), .out2(out2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] d);
    in1 = a;
    in2 = b;
    w1  = c;
    w2  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    apply(64'h3F800000_00000000, 64'h40000000_00000000,
          64'h3F800000_00000000, 64'hBF800000_00000000);
    tick;
    chk("rst_out1", out1, 64'h0);
    chk("rst_out2", out2, 64'h0);
    tick;
    chk("rst_hold_out1", out1, 64'h0);

    reset = 1'b0;
    tick;
    chk("bfly_out1", out1, 64'h40400000_00000000);
    chk("bfly_out2", out2, 64'hBF800000_00000000);

    apply(64'h0, 64'h00000000_3F800000, 64'h00000000_BF800000, 64'h00000000_3F800000);
    #2;
    chk("hold_out1", out1, 64'h40400000_00000000);
    tick;
    chk("imag_out1", out1, 64'h3F800000_00000000);
    chk("imag_out2", out2, 64'hBF800000_00000000);

    apply(64'h0, 64'h3F800000_00000000, 64'h3F34FDF4_BF34FDF4, 64'hBF34FDF4_3F34FDF4);
    tick;
    chk("pass_out1", out1, 64'h3F34FDF4_BF34FDF4);
    chk("pass_out2", out2, 64'hBF34FDF4_3F34FDF4);

    apply(64'h3F800000_00000000, 64'h40000000_00000000,
          64'h3F800000_00000000, 64'hBF800000_00000000);
    reset = 1'b1;
    tick;
    chk("midrst_out1", out1, 64'h0);
    chk("midrst_out2", out2, 64'h0);
    reset = 1'b0;
    apply(64'h0, 64'h00000000_3F800000, 64'h00000000_BF800000, 64'h00000000_3F800000);
    tick;
    chk("post_rst_out1", out1, 64'h3F800000_00000000);
    chk("post_rst_out2", out2, 64'hBF800000_00000000);

    apply(64'h3F800000_00000000, 64'hBF800000_00000000, 64'h3F800000_00000000, 64'h0);
    tick;
    chk("cancel_out1", out1, 64'h0);
    chk("cancel_out2", out2, 64'h3F800000_00000000);

    apply(64'h80400000_00000000, 64'h80000001_00000000, 64'h3F800000_00000000, 64'h0);
    tick;
    chk("denorm_out1", out1, 64'h80000000_00000000);
    chk("denorm_out2", out2, 64'h80000000_00000000);

    apply(64'h0, 64'h1C800000_00000000, 64'h1C800000_00000000, 64'h0);
    tick;
    chk("underflow_out1", out1, 64'h0);

    apply(64'h7F7FFFFF_00000000, 64'h7F7FFFFF_00000000, 64'h3F800000_00000000, 64'h0);
    tick;
    chk("ovf_out1", out1, 64'h7F800000_00000000);
    chk("ovf_out2", out2, 64'h7F7FFFFF_00000000);

    apply(64'h7F7FFFFF_00000000, 64'h7F800000_00000000, 64'h3F800000_00000000, 64'h0);
    tick;
    chk("inf_out1", out1, 64'h7FC00000_7FC00000);
    chk("inf_out2", out2, 64'h7FC00000_7FC00000);

    apply(64'h3F800000_00000000, 64'h33800000_00000000, 64'h3F800000_00000000, 64'h0);
    tick;
    chk("tie_out1", out1, 64'h3F800000_00000000);
    chk("tie_out2", out2, 64'h3F800000_00000000);

    apply(64'h3F800000_00000000, 64'h33800001_00000000, 64'h3F800000_00000000, 64'h0);
    tick;
`ifdef MAC_RNE_EN
    chk("above_tie_out1", out1, 64'h3F800001_00000000);
`else
    chk("above_tie_out1", out1, 64'h3F800000_00000000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac.md
MAC -- requirements
Module: mac

Interface
REQ-001 The port clk SHALL be a 1-bit input: the clock; all state updates on its rising edge.
REQ-002 The port reset SHALL be a 1-bit input: reset, synchronous, active-high.
REQ-003 The port in1 SHALL be a 64-bit input: complex operand A, packed {re[63:32], im[31:0]}, each half IEEE-754 binary32.
REQ-004 The port in2 SHALL be a 64-bit input: complex operand B, same packing.
REQ-005 The port w1 SHALL be a 64-bit input: complex twiddle W1, same packing.
REQ-006 The port w2 SHALL be a 64-bit input: complex twiddle W2, same packing.
REQ-007 The port out1 SHALL be a 64-bit output: registered result Y1, same packing.
REQ-008 The port out2 SHALL be a 64-bit output: registered result Y2, same packing.
REQ-009 Port order SHALL be clk, reset, in1, in2, w1, w2, out1, out2.

Function
REQ-010 The block SHALL compute Y1 = A + W1·B and Y2 = A + W2·B.
- Complex product: re = wr·br − wi·bi; im = wr·bi + wi·br.
- The result adds A's re and im parts.
REQ-011 W1 and W2 SHALL be treated as independent; the block SHALL NOT assume W2 = −W1.
REQ-012 Evaluation order SHALL be fixed.
- Four products first, each rounded.
- Then the product sum or difference, rounded.
- Then the A addition, rounded.
- No fused operations.
REQ-013 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on out1/out2 after edge N, held until the next edge.
REQ-014 There SHALL be no handshake; a new operation is accepted every cycle.
REQ-015 Denormal inputs SHALL be flushed to signed zero; denormal results SHALL be flushed to signed zero.
REQ-016 Overflow SHALL produce signed infinity (exp=0xFF, mant=0).
REQ-017 Any Inf or NaN operand feeding an operation SHALL produce canonical NaN 0x7FC00000 for that operation.
REQ-018 Exact-zero sums of opposite-signed operands SHALL give +0; the product of zeros SHALL carry the XOR of the operand signs.
REQ-019 Default rounding SHALL be round-toward-zero (truncation).

Reset
REQ-020 With reset high at a rising edge, out1 and out2 SHALL become 64'h0 at that edge, regardless of inputs.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result; the first valid result is for inputs sampled at the first edge with reset low.

Configuration
REQ-022 With macro MAC_RNE_EN defined, every multiply and add SHALL round to nearest, ties-to-even; without it, truncation per REQ-019.
REQ-023 MAC_RNE_EN SHALL NOT alter latency, ports, or special-value rules.

Structure
REQ-024 Package mac_pkg SHALL hold the following:
- Constants: FP32 width 32, exponent width 8, mantissa width 23, bias 127, canonical NaN, +Inf.
- Complex field positions: RE_MSB=63, RE_LSB=32, IM_MSB=31, IM_LSB=0.
- Functions fp32_mul and fp32_add implementing REQ-015..019/022.
REQ-025 Sub-module mac_cmul SHALL compute the complex product W·B combinationally; mac SHALL instantiate it twice, once for W1 and once for W2.
REQ-026 mac SHALL perform the A additions and own the output register.

Verification
REQ-027 Basic butterfly: in1=3F800000_00000000, in2=40000000_00000000, w1=3F800000_00000000, w2=BF800000_00000000 -> out1=40400000_00000000 (3+0j), out2=BF800000_00000000 (−1+0j), one cycle later.
REQ-028 Imaginary twiddles: in1=0, in2=00000000_3F800000, w1=00000000_BF800000, w2=00000000_3F800000 -> out1=3F800000_00000000, out2=BF800000_00000000.
REQ-029 Exact pass-through: in1=0, in2=3F800000_00000000, w1=3F34FDF4_BF34FDF4, w2=BF34FDF4_3F34FDF4 -> out1=3F34FDF4_BF34FDF4, out2=BF34FDF4_3F34FDF4.
REQ-030 Reset and latency: drive the REQ-027 vector with reset high -> outputs 0. Deassert reset -> the result appears after the next edge. Change inputs on consecutive cycles -> outputs track with exactly 1-cycle lag.
REQ-031 Overflow/special values: in1=7F7FFFFF_00000000, in2=7F7FFFFF_00000000, w1=3F800000_00000000 -> out1 re=7F800000. in2 re=7F800000 (Inf) -> affected fields=7FC00000.
REQ-032 Rounding: in1=3F800000_0, in2=33800000_0 (2^-24), w1=3F800000_0 -> out1 re=3F800000 without MAC_RNE_EN. With MAC_RNE_EN, the tie also gives 3F800000; in2=33800001 gives 3F800001.
